// File: rtl/uart_rx_ctrl_if.sv
// Received-byte result bus: the receiver drives data, strobes and the busy flag.
interface uart_rx_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_int;

  modport master (output rx_data, output rx_valid, output frame_err, output rx_int);
  modport slave  (input  rx_data, input  rx_valid, input  frame_err, input  rx_int);
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receiver FSM driven by an external mid-bit baud strobe; 8N1 with optional parity.
// Result strobe lands 1 clk after the stop-bit clk_bps pulse; no backpressure, results are single-cycle pulses.
module uart_rx_ctrl #(
  parameter int PARITY = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rs232_rx,
  input  logic            clk_bps,
  output logic            bps_start,
  uart_rx_ctrl_if.master  rx_bus
);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  // Unsupported PARITY values fall back to no parity.
  localparam bit HAS_PAR = (PARITY == 1) || (PARITY == 2);
  localparam bit ODD_PAR = (PARITY == 2);

  logic       rx_s1, rx_s2, rx_h1, rx_h2;
  logic       fall;

  state_t     state, state_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shift, shift_nxt;
  logic       par_bit, par_nxt;
  logic [7:0] data_nxt;
  logic       valid_nxt, err_nxt;
  logic       busy, busy_nxt;
  logic       par_err;

  // Sync and history flops idle high so reset never fabricates a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_h1 <= 1'b1;
      rx_h2 <= 1'b1;
    end else begin
      rx_s1 <= rs232_rx;
      rx_s2 <= rx_s1;
      rx_h1 <= rx_s2;
      rx_h2 <= rx_h1;
    end
  end

  assign fall    = rx_h2 & ~rx_h1;
  assign par_err = HAS_PAR && ((^shift ^ par_bit) != ODD_PAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      bit_cnt          <= 3'd0;
      shift            <= 8'h00;
      par_bit          <= 1'b0;
      busy             <= 1'b0;
      rx_bus.rx_data   <= 8'h00;
      rx_bus.rx_valid  <= 1'b0;
      rx_bus.frame_err <= 1'b0;
    end else begin
      state            <= state_nxt;
      bit_cnt          <= bit_cnt_nxt;
      shift            <= shift_nxt;
      par_bit          <= par_nxt;
      busy             <= busy_nxt;
      rx_bus.rx_data   <= data_nxt;
      rx_bus.rx_valid  <= valid_nxt;
      rx_bus.frame_err <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    par_nxt     = par_bit;
    data_nxt    = rx_bus.rx_data;
    valid_nxt   = 1'b0;
    err_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (fall) state_nxt = START;
      end
      START: begin
        // A high sample at mid start bit means the edge was only a glitch.
        if (clk_bps) begin
          if (!rx_s2) begin
            state_nxt   = DATA;
            bit_cnt_nxt = 3'd0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (clk_bps) begin
          shift_nxt   = {rx_s2, shift[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = HAS_PAR ? PAR : STOP;
        end
      end
      PAR: begin
        if (clk_bps) begin
          par_nxt   = rx_s2;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (clk_bps) begin
          state_nxt = IDLE;
          if (rx_s2 && !par_err) begin
            data_nxt  = shift;
            valid_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  assign bps_start     = busy;
  assign rx_bus.rx_int = busy;

endmodule
